hazard_mem_unit: RTL and testbench

- Parametrised successor to the fixed 5-stage hazard/forwarding logic that drives our pipelined RISC-V datapath.
- Provides the existing duties: E-stage forwarding, load-use stall and taken-branch flush.
- Adds a variable-latency data-memory handshake: the whole pipeline freezes while an M-stage access waits on `dmem_ready`. A watchdog FSM raises a sticky timeout.
- Adds saturating performance counters for stall and flush cycles.
- Sits beside the datapath and drives its Stall*/Flush*/Forward* inputs.

---
 rtl/hazard_mem_unit_pkg.sv | 19 +
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_mem_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_mem_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_mem_unit_pkg.sv
// Shared definitions for the hazard / memory-handshake unit.
//   FWD_*          : forwarding mux select encodings for ForwardAE/ForwardBE
//   memState_t     : data-memory handshake FSM states
//   RESULTSRC_LOAD : ResultSrc encoding of a load instruction
package hazard_mem_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;   // operand from ResultW
    localparam logic [1:0] FWD_M  = 2'b10;   // operand from ALUResultM

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } memState_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count this cycle
//   count      : current value (registered)
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_mem_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline: E-stage forwarding, load-use
// stall, taken-branch flush, a variable-latency data-memory handshake that
// freezes the pipeline, a watchdog with a sticky timeout, and saturating
// stall/flush performance counters.
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW : register addresses per stage
//   ResultSrcE0, RegWriteM/W, PCSrcE   : instruction attributes per stage
//   MemAccessM, dmem_ready             : M-stage memory handshake
//   Stall*/Flush*/Forward*             : datapath control (combinational)
//   mem_timeout, stall_cnt, flush_cnt  : status (registered)
module hazard_mem_unit
    import hazard_mem_unit_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              ResultSrcE0,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MemAccessM,
    input  logic              dmem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    memState_t         state, stateNext;
    logic [TO_W-1:0]   waitCnt, waitCntNext;
    logic              timeoutNext;
    logic              isLoadE;
    logic              lwStall;
    logic              memStall;
    logic              branchApplied;
    logic              lwApplied;

    // Forwarding: newest producer (M) beats older one (W); x0 never forwards.
    always_comb begin
        ForwardAE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = FWD_W;
        end

        ForwardBE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = FWD_W;
        end
    end

    // Only the low ResultSrc bit reaches this block; the high bit is 0 for loads.
    assign isLoadE = ({1'b0, ResultSrcE0} == RESULTSRC_LOAD);
    assign lwStall = isLoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Freeze while an M access is outstanding, and forever once faulted.
    assign memStall = ((state == RUN)      && MemAccessM && !dmem_ready) ||
                      ((state == MEM_WAIT) && !dmem_ready) ||
                      (state == FAULT);

    // A frozen pipeline holds the branch/load in E; apply them once it moves.
    assign branchApplied = PCSrcE && !memStall;
    assign lwApplied     = lwStall && !PCSrcE && !memStall;

    assign StallF = memStall || lwApplied;
    assign StallD = memStall || lwApplied;
    assign StallE = memStall;
    assign StallM = memStall;
    assign FlushD = branchApplied;
    assign FlushE = branchApplied || lwApplied;
    assign FlushW = memStall;

    // Memory handshake FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            mem_timeout <= timeoutNext;
        end
    end

    // Memory handshake FSM next state; waitCnt counts stalled access cycles.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        timeoutNext = mem_timeout;
        case (state)
            RUN: begin
                if (MemAccessM && !dmem_ready) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == TO_W'(TIMEOUT)) begin
                    stateNext   = FAULT;
                    timeoutNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + TO_W'(1);
                end
            end
            FAULT: begin
                stateNext = FAULT;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (StallF),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (branchApplied),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_mem_unit.sv
// Self-checking bench for hazard_mem_unit (TIMEOUT=8, CNT_W=3).
module tb_hazard_mem_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;
    logic [2:0] stall_cnt, flush_cnt;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    hazard_mem_unit #(.REG_AW(5), .TIMEOUT(8), .TO_W(8), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // exp = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    typedef struct {
        logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic        ld, rwM, rwW, pc;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mv(input int r1d, input int r2d, input int r1e, input int r2e,
                                input int rde, input int rdm, input int rdw,
                                input logic ld, input logic rwm, input logic rww,
                                input logic pc, input logic [10:0] e);
        vec_t v;
        v.rs1D = 5'(r1d); v.rs2D = 5'(r2d); v.rs1E = 5'(r1e); v.rs2E = 5'(r2e);
        v.rdE = 5'(rde); v.rdM = 5'(rdm); v.rdW = 5'(rdw);
        v.ld = ld; v.rwM = rwm; v.rwW = rww; v.pc = pc; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemAccessM = 1'b0; dmem_ready = 1'b0;
    endtask

    // Reset for two cycles, leaving the bench at a falling edge with reset released.
    task automatic doReset();
        idle();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [4:0] memBundle();
        return {StallF, StallD, StallE, StallM, FlushW};
    endfunction

    initial begin
        vecs[0]  = mv(0, 0, 5,  3,  0, 5,  5,  1'b0, 1'b1, 1'b1, 1'b0, 11'b10_00_0000000);
        vecs[1]  = mv(0, 0, 0,  0,  0, 0,  0,  1'b0, 1'b1, 1'b1, 1'b0, 11'b00_00_0000000);
        vecs[2]  = mv(0, 0, 6,  6,  0, 6,  6,  1'b0, 1'b0, 1'b1, 1'b0, 11'b01_01_0000000);
        vecs[3]  = mv(0, 0, 9,  9,  0, 9,  9,  1'b0, 1'b1, 1'b1, 1'b0, 11'b10_10_0000000);
        vecs[4]  = mv(0, 0, 12, 12, 0, 11, 12, 1'b0, 1'b1, 1'b1, 1'b0, 11'b01_01_0000000);
        vecs[5]  = mv(1, 7, 0,  0,  7, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_1100010);
        vecs[6]  = mv(1, 7, 0,  0,  0, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000);
        vecs[7]  = mv(7, 0, 0,  0,  7, 0,  0,  1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000);
        vecs[8]  = mv(0, 0, 0,  0,  0, 0,  0,  1'b0, 1'b0, 1'b0, 1'b1, 11'b00_00_0000110);
        vecs[9]  = mv(4, 0, 0,  0,  4, 0,  0,  1'b1, 1'b0, 1'b0, 1'b1, 11'b00_00_0000110);
        vecs[10] = mv(4, 0, 0,  0,  4, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_1100010);
        vecs[11] = mv(0, 0, 3,  3,  0, 3,  0,  1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000);

        idle();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_outputs", 32'({memBundle(), FlushD, FlushE, ForwardAE, ForwardBE}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table of single-cycle forwarding / hazard vectors.
        for (int i = 0; i < 12; i++) begin
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D;
            Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
            ResultSrcE0 = vecs[i].ld; RegWriteM = vecs[i].rwM;
            RegWriteW = vecs[i].rwW; PCSrcE = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d", i),
                32'({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                     FlushD, FlushE, FlushW}),
                32'(vecs[i].exp));
            @(negedge clk);
        end
        idle();
        #1;
        chk("table_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("table_flush_cnt", 32'(flush_cnt), 32'd2);

        // Load-use stall lasts one cycle and counts once.
        doReset();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk("lw_stall", 32'({StallF, StallD, FlushE}), 32'b111);
        @(negedge clk);
        idle();
        #1;
        chk("lw_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lw_released", 32'(StallF), 32'd0);

        // Four-cycle memory wait, then ready retires with no extra stall.
        doReset();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memwait_c%0d", i), 32'(memBundle()), 32'b11111);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        chk("memwait_ready", 32'(memBundle()), 32'b00000);
        @(negedge clk);
        idle();
        #1;
        chk("memwait_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("memwait_back_run", 32'(memBundle()), 32'b00000);

        // Branch held under a memory stall is applied once the stall drops.
        doReset();
        PCSrcE = 1'b1; MemAccessM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("br_held_c%0d", i), 32'({StallF, FlushD, FlushE}), 32'b100);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        chk("br_applied", 32'({StallF, FlushD, FlushE}), 32'b011);
        @(negedge clk);
        idle();
        #1;
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd3);

        // Watchdog: RUN cycle plus 8 MEM_WAIT cycles, then sticky FAULT.
        doReset();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_wait_c%0d", i), 32'(memBundle()), 32'b11111);
            @(negedge clk);
        end
        #1;
        chk("to_not_yet", 32'(mem_timeout), 32'd0);
        chk("to_last_wait", 32'(memBundle()), 32'b11111);
        @(negedge clk);
        #1;
        chk("to_set", 32'(mem_timeout), 32'd1);
        MemAccessM = 1'b0; dmem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("fault_hold_c%0d", i), 32'(memBundle()), 32'b11111);
            @(negedge clk);
        end
        #1;
        chk("fault_sticky", 32'(mem_timeout), 32'd1);
        chk("stall_cnt_sat", 32'(stall_cnt), 32'd7);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_stall", 32'(memBundle()), 32'b00000);
        chk("async_rst_timeout", 32'(mem_timeout), 32'd0);
        chk("async_rst_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dmem_ready = 1'b0;
        #1;
        chk("post_rst_idle", 32'(memBundle()), 32'b00000);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
